// File: rtl/mem_addr_browser.sv
// Push-button memory address navigator: 2-flop sync, debounce, INC/DEC/PAGE/HOME with auto-repeat.
// Address and step update DEBOUNCE_CYC edges after the synchronised press is first seen; no backpressure.
module mem_addr_browser #(
    parameter int          ADDR_W       = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned PAGE         = 16,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned REPEAT_DELAY = 1000,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter bit          WRAP         = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        switch,
    input  logic              en,
    output logic [ADDR_W-1:0] address,
    output logic              step,
    output logic              at_min,
    output logic              at_max
);

    localparam int AW1     = ADDR_W + 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_X    = AW1'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = AW1'(DEPTH);
    localparam logic [ADDR_W:0]   PAGE_X    = AW1'(PAGE);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0]  DLY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]  RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB,
        ST_HOLD,
        ST_RPT,
        ST_REL
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_INC,
        ACT_DEC,
        ACT_PAGE,
        ACT_HOME
    } act_t;

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    state_t            state_q, state_d;
    logic [3:0]        pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              step_q, step_d;

    logic [3:0]        s;
    act_t              act;
    logic              apply;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] new_addr;

    assign s = sync2_q;

    always_comb begin
        sync1_d = switch;
        sync2_d = sync1_q;
    end

    // Only a single pressed button maps to an action; any chord is inert.
    always_comb begin
        act = ACT_NONE;
        case (pat_q)
            4'b1110: act = ACT_INC;
            4'b1101: act = ACT_DEC;
            4'b1011: act = ACT_PAGE;
            4'b0111: act = ACT_HOME;
            default: act = ACT_NONE;
        endcase
    end

    always_comb begin
        sum      = {1'b0, address_q} + PAGE_X;
        new_addr = address_q;
        case (act)
            ACT_INC: begin
                if (address_q == LAST_A) begin
                    new_addr = WRAP ? '0 : address_q;
                end else begin
                    new_addr = address_q + 1'b1;
                end
            end
            ACT_DEC: begin
                if (address_q == '0) begin
                    new_addr = WRAP ? LAST_A : address_q;
                end else begin
                    new_addr = address_q - 1'b1;
                end
            end
            ACT_PAGE: begin
                if (sum > LAST_X) begin
                    new_addr = WRAP ? ADDR_W'(sum - DEPTH_X) : LAST_A;
                end else begin
                    new_addr = ADDR_W'(sum);
                end
            end
            ACT_HOME: new_addr = '0;
            default:  new_addr = address_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s != 4'hF) begin
                    pat_d   = s;
                    cnt_d   = '0;
                    state_d = ST_DEB;
                end
            end
            ST_DEB: begin
                if (s != pat_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    apply   = 1'b1;
                    rpt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (s != pat_q) begin
                    cnt_d   = '0;
                    state_d = ST_REL;
                end else if (rpt_q == DLY_LAST) begin
                    // PAGE/HOME/NONE park here with rpt pinned until release.
                    if (act == ACT_INC || act == ACT_DEC) begin
                        apply   = 1'b1;
                        rpt_d   = '0;
                        state_d = ST_RPT;
                    end
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            ST_RPT: begin
                if (s != pat_q) begin
                    cnt_d   = '0;
                    state_d = ST_REL;
                end else if (rpt_q == RATE_LAST) begin
                    apply = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            ST_REL: begin
                if (s != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        address_d = address_q;
        step_d    = 1'b0;
        if (apply && en && (new_addr != address_q)) begin
            address_d = new_addr;
            step_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            state_q   <= ST_IDLE;
            pat_q     <= 4'hF;
            cnt_q     <= '0;
            rpt_q     <= '0;
            address_q <= '0;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            address_q <= address_d;
            step_q    <= step_d;
        end
    end

    assign address = address_q;
    assign step    = step_q;
    assign at_min  = (address_q == '0);
    assign at_max  = (address_q == LAST_A);

endmodule

// File: tb/tb_mem_addr_browser.sv
// Directed bench for mem_addr_browser: one wrapping and one saturating instance share the same stimulus.
module tb_mem_addr_browser;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    sw;
    logic [AW-1:0] addr_w, addr_s;
    logic          step_w, step_s, min_w, max_w, min_s, max_s;

    int n_cmp = 0;
    int n_bad = 0;
    int nw, ns, fw, lw;
    int wt [4];

    always #5 clk = ~clk;

    mem_addr_browser #(.ADDR_W(AW), .DEPTH(10), .PAGE(4), .DEBOUNCE_CYC(4),
                       .REPEAT_DELAY(8), .REPEAT_RATE(3), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .switch(sw), .en(en),
        .address(addr_w), .step(step_w), .at_min(min_w), .at_max(max_w)
    );

    mem_addr_browser #(.ADDR_W(AW), .DEPTH(10), .PAGE(4), .DEBOUNCE_CYC(4),
                       .REPEAT_DELAY(8), .REPEAT_RATE(3), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .switch(sw), .en(en),
        .address(addr_s), .step(step_s), .at_min(min_s), .at_max(max_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        sw  = 4'hF;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Hold pat for 'hold' edges, release, keep observing until 'total' edges; records step timing.
    task automatic run_press(input logic [3:0] pat, input int hold, input int total);
        nw = 0; ns = 0; fw = 0; lw = 0;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int t = 1; t <= total; t++) begin
            sw = (t <= hold) ? pat : 4'hF;
            tick;
            if (step_w) begin
                if (nw < 4) wt[nw] = t;
                if (fw == 0) fw = t;
                lw = t;
                nw++;
            end
            if (step_s) ns++;
        end
        sw = 4'hF;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; sw = 4'hF;
        tick; tick; tick;
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL reset_addr_w: got %0d want 0", addr_w); end
        n_cmp++; if (addr_s !== 8'd0) begin n_bad++; $display("FAIL reset_addr_s: got %0d want 0", addr_s); end
        n_cmp++; if (step_w !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b want 0", step_w); end
        n_cmp++; if (min_w !== 1'b1) begin n_bad++; $display("FAIL reset_at_min: got %b want 1", min_w); end
        n_cmp++; if (max_w !== 1'b0) begin n_bad++; $display("FAIL reset_at_max: got %b want 0", max_w); end
        rst = 1'b0;
    endtask

    task automatic test_single_inc;
        do_reset;
        run_press(4'b1110, 6, 20);
        n_cmp++; if (fw != 7) begin n_bad++; $display("FAIL inc_step_edge: got %0d want 7", fw); end
        n_cmp++; if (nw != 1) begin n_bad++; $display("FAIL inc_step_count: got %0d want 1", nw); end
        n_cmp++; if (addr_w !== 8'd1) begin n_bad++; $display("FAIL inc_addr_w: got %0d want 1", addr_w); end
        n_cmp++; if (addr_s !== 8'd1) begin n_bad++; $display("FAIL inc_addr_s: got %0d want 1", addr_s); end
    endtask

    task automatic test_bounce;
        int steps;
        do_reset;
        steps = 0;
        for (int t = 1; t <= 20; t++) begin
            sw = (t <= 2 || t == 4 || t == 5) ? 4'b1110 : 4'hF;
            tick;
            if (step_w || step_s) steps++;
        end
        sw = 4'hF;
        n_cmp++; if (steps != 0) begin n_bad++; $display("FAIL bounce_steps: got %0d want 0", steps); end
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL bounce_addr: got %0d want 0", addr_w); end
    endtask

    task automatic test_dec_wrap;
        do_reset;
        run_press(4'b1101, 6, 20);
        n_cmp++; if (addr_w !== 8'd9) begin n_bad++; $display("FAIL dec_wrap_addr: got %0d want 9", addr_w); end
        n_cmp++; if (max_w !== 1'b1) begin n_bad++; $display("FAIL dec_wrap_at_max: got %b want 1", max_w); end
        n_cmp++; if (nw != 1) begin n_bad++; $display("FAIL dec_wrap_steps: got %0d want 1", nw); end
        n_cmp++; if (addr_s !== 8'd0) begin n_bad++; $display("FAIL dec_sat_addr: got %0d want 0", addr_s); end
        n_cmp++; if (min_s !== 1'b1) begin n_bad++; $display("FAIL dec_sat_at_min: got %b want 1", min_s); end
        n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL dec_sat_steps: got %0d want 0", ns); end
    endtask

    task automatic test_page_home;
        do_reset;
        // INC held 32 edges: applies at 7,15,18,...,33 -> eight increments.
        run_press(4'b1110, 32, 50);
        n_cmp++; if (nw != 8) begin n_bad++; $display("FAIL climb_steps_w: got %0d want 8", nw); end
        n_cmp++; if (ns != 8) begin n_bad++; $display("FAIL climb_steps_s: got %0d want 8", ns); end
        n_cmp++; if (addr_w !== 8'd8) begin n_bad++; $display("FAIL climb_addr_w: got %0d want 8", addr_w); end
        n_cmp++; if (addr_s !== 8'd8) begin n_bad++; $display("FAIL climb_addr_s: got %0d want 8", addr_s); end
        run_press(4'b1011, 6, 20);
        n_cmp++; if (addr_w !== 8'd2) begin n_bad++; $display("FAIL page_wrap_addr: got %0d want 2", addr_w); end
        n_cmp++; if (addr_s !== 8'd9) begin n_bad++; $display("FAIL page_sat_addr: got %0d want 9", addr_s); end
        n_cmp++; if (max_s !== 1'b1) begin n_bad++; $display("FAIL page_sat_at_max: got %b want 1", max_s); end
        run_press(4'b0111, 6, 20);
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL home_addr_w: got %0d want 0", addr_w); end
        n_cmp++; if (addr_s !== 8'd0) begin n_bad++; $display("FAIL home_addr_s: got %0d want 0", addr_s); end
        n_cmp++; if (fw != 7) begin n_bad++; $display("FAIL home_step_edge: got %0d want 7", fw); end
        n_cmp++; if (ns != 1) begin n_bad++; $display("FAIL home_steps_s: got %0d want 1", ns); end
        run_press(4'b0111, 6, 20);
        n_cmp++; if (nw + ns != 0) begin n_bad++; $display("FAIL home_at_zero_steps: got %0d want 0", nw + ns); end
    endtask

    task automatic test_repeat;
        do_reset;
        run_press(4'b1110, 37, 60);
        n_cmp++; if (wt[0] != 7) begin n_bad++; $display("FAIL rpt_first: got %0d want 7", wt[0]); end
        n_cmp++; if (wt[1] != 15) begin n_bad++; $display("FAIL rpt_delay: got %0d want 15", wt[1]); end
        n_cmp++; if (wt[2] != 18) begin n_bad++; $display("FAIL rpt_rate1: got %0d want 18", wt[2]); end
        n_cmp++; if (wt[3] != 21) begin n_bad++; $display("FAIL rpt_rate2: got %0d want 21", wt[3]); end
        n_cmp++; if (lw != 39) begin n_bad++; $display("FAIL rpt_last: got %0d want 39", lw); end
        n_cmp++; if (nw != 10) begin n_bad++; $display("FAIL rpt_count_w: got %0d want 10", nw); end
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL rpt_wrap_addr: got %0d want 0", addr_w); end
        n_cmp++; if (ns != 9) begin n_bad++; $display("FAIL rpt_count_s: got %0d want 9", ns); end
        n_cmp++; if (addr_s !== 8'd9) begin n_bad++; $display("FAIL rpt_sat_addr: got %0d want 9", addr_s); end
        run_press(4'b1011, 37, 60);
        n_cmp++; if (nw != 1) begin n_bad++; $display("FAIL page_hold_steps: got %0d want 1", nw); end
        n_cmp++; if (addr_w !== 8'd4) begin n_bad++; $display("FAIL page_hold_addr: got %0d want 4", addr_w); end
        n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL page_sat_nop_steps: got %0d want 0", ns); end
        run_press(4'b1101, 6, 20);
        n_cmp++; if (addr_w !== 8'd3) begin n_bad++; $display("FAIL dec_mid_addr_w: got %0d want 3", addr_w); end
        n_cmp++; if (addr_s !== 8'd8) begin n_bad++; $display("FAIL dec_mid_addr_s: got %0d want 8", addr_s); end
    endtask

    task automatic test_chord_rst_en;
        do_reset;
        run_press(4'b1100, 20, 40);
        n_cmp++; if (nw + ns != 0) begin n_bad++; $display("FAIL chord_steps: got %0d want 0", nw + ns); end
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL chord_addr: got %0d want 0", addr_w); end

        do_reset;
        sw = 4'b1110;
        for (int t = 1; t <= 16; t++) tick;
        n_cmp++; if (addr_w !== 8'd2) begin n_bad++; $display("FAIL pre_rst_addr: got %0d want 2", addr_w); end
        rst = 1'b1;
        tick;
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL mid_rst_addr_w: got %0d want 0", addr_w); end
        n_cmp++; if (addr_s !== 8'd0) begin n_bad++; $display("FAIL mid_rst_addr_s: got %0d want 0", addr_s); end
        n_cmp++; if (step_w !== 1'b0) begin n_bad++; $display("FAIL mid_rst_step: got %b want 0", step_w); end
        rst = 1'b0;
        for (int t = 18; t <= 23; t++) tick;
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL redeb_early: got %0d want 0", addr_w); end
        tick;
        n_cmp++; if (addr_w !== 8'd1) begin n_bad++; $display("FAIL redeb_addr: got %0d want 1", addr_w); end
        n_cmp++; if (step_w !== 1'b1) begin n_bad++; $display("FAIL redeb_step: got %b want 1", step_w); end
        sw = 4'hF;
        repeat (15) tick;

        do_reset;
        en = 1'b0;
        run_press(4'b1110, 6, 20);
        n_cmp++; if (nw + ns != 0) begin n_bad++; $display("FAIL en_off_steps: got %0d want 0", nw + ns); end
        n_cmp++; if (addr_w !== 8'd0) begin n_bad++; $display("FAIL en_off_addr: got %0d want 0", addr_w); end
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        sw  = 4'hF;
        test_reset;
        test_single_inc;
        test_bounce;
        test_dec_wrap;
        test_page_home;
        test_repeat;
        test_chord_rst_en;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
